// File: rtl/ram_readout.sv
// ram_readout: streams a finished capture out of the four sample RAMs as bytes.
// The record starts triggerpoint samples before the trigger address, wraps around
// the circular buffer, and is sent channel by channel, lowest enabled channel first.
module ram_readout #(
  parameter int unsigned ram_width = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 data_ready,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] triggerpoint,
  input  logic [ram_width:0]   readlen,
  input  logic [3:0]           chanmask,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  input  logic [7:0]           q1,
  input  logic [7:0]           q2,
  input  logic [7:0]           q3,
  input  logic [7:0]           q4,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StCapt  = 3'd3;
  localparam logic [2:0] StSend  = 3'd4;

  localparam logic [ram_width:0] CntOne = {{ram_width{1'b0}}, 1'b1};

  logic [2:0]           state_q, state_d;
  logic [ram_width-1:0] base_q, base_d;
  logic [ram_width:0]   len_q, len_d;
  logic [3:0]           mask_q, mask_d;
  logic [1:0]           ch_q, ch_d;
  logic [ram_width:0]   cnt_q, cnt_d;
  logic                 abort_q, abort_d;

  logic                 rden_d;
  logic [ram_width-1:0] rdaddress_d;
  logic [7:0]           tx_data_d;
  logic                 tx_valid_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 err_d;

  logic                 abort_now;
  logic [ram_width:0]   cnt_inc;
  logic [3:0]           mask_rest;
  logic                 go_issue;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else return 2'd3;
  endfunction

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    rden_d      = 1'b0;
    rdaddress_d = rdaddress;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    done_d      = 1'b0;
    err_d       = 1'b0;
    go_issue    = 1'b0;

    // A falling data_ready is remembered so a byte in flight can still finish.
    abort_now = abort_q | ~data_ready;
    cnt_inc   = cnt_q + CntOne;
    mask_rest = mask_q & ~(4'b0001 << ch_q);

    case (state_q)
      StIdle: begin
        if (start && data_ready) begin
          state_d = StSetup;
          base_d  = wraddress_triggerpoint - triggerpoint;
          len_d   = readlen;
          mask_d  = chanmask;
          abort_d = 1'b0;
        end
      end
      StSetup: begin
        if ((len_q == '0) || (mask_q == 4'b0000)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (abort_now) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          ch_d     = lowest_bit(mask_q);
          cnt_d    = '0;
          go_issue = 1'b1;
        end
      end
      StIssue: begin
        if (abort_now) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        if (abort_now) begin
          // Pending read data is simply never sampled.
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d    = StSend;
          tx_valid_d = 1'b1;
          case (ch_q)
            2'd0:    tx_data_d = q1;
            2'd1:    tx_data_d = q2;
            2'd2:    tx_data_d = q3;
            default: tx_data_d = q4;
          endcase
        end
      end
      StSend: begin
        abort_d = abort_now;
        if (tx_valid && tx_ready) begin
          tx_valid_d = 1'b0;
          if (abort_now) begin
            state_d = StIdle;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cnt_inc != len_q) begin
            cnt_d    = cnt_inc;
            go_issue = 1'b1;
          end else if (mask_rest != 4'b0000) begin
            mask_d   = mask_rest;
            ch_d     = lowest_bit(mask_rest);
            cnt_d    = '0;
            go_issue = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Address arithmetic is ram_width bits wide, so it wraps around the buffer.
    if (go_issue) begin
      state_d     = StIssue;
      rden_d      = 1'b1;
      rdaddress_d = base_q + cnt_d[ram_width-1:0];
    end

    busy_d = (state_d != StIdle);
  end

  // Control state and request parameters latched at start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rden      <= 1'b0;
      rdaddress <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rden      <= rden_d;
      rdaddress <= rdaddress_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_readout.sv
// Bench for ram_readout: RAM model, expected address/byte stream model, per-cycle compare.
module tb_ram_readout;
  localparam int unsigned W     = 10;
  localparam int          Depth = 1 << W;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] wtp = '0;
  logic [W-1:0] tp = '0;
  logic [W:0]   readlen = '0;
  logic [3:0]   chanmask = '0;
  logic         rden;
  logic [W-1:0] rdaddress;
  logic [7:0]   q1 = '0, q2 = '0, q3 = '0, q4 = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         busy, done, err;

  ram_readout #(.ram_width(W)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .start                  (start),
    .data_ready             (data_ready),
    .wraddress_triggerpoint (wtp),
    .triggerpoint           (tp),
    .readlen                (readlen),
    .chanmask               (chanmask),
    .rden                   (rden),
    .rdaddress              (rdaddress),
    .q1                     (q1),
    .q2                     (q2),
    .q3                     (q3),
    .q4                     (q4),
    .tx_data                (tx_data),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .busy                   (busy),
    .done                   (done),
    .err                    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: channel c holds addr[7:0] with the top two bits flipped by c.
  function automatic logic [7:0] ram_val(input int ch, input int addr);
    return 8'(addr) ^ 8'(ch << 6);
  endfunction

  // One-cycle read latency sample RAMs.
  always @(posedge clk) begin
    if (rden) begin
      q1 <= ram_val(0, int'(rdaddress));
      q2 <= ram_val(1, int'(rdaddress));
      q3 <= ram_val(2, int'(rdaddress));
      q4 <= ram_val(3, int'(rdaddress));
    end
  end

  bit   rand_mode = 1'b0;
  logic ready_fixed = 1'b1;
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // Model: expected read addresses and bytes, in order.
  int         exp_addr[$];
  logic [7:0] exp_byte[$];
  // Observations.
  int         got_addr[$];
  logic [7:0] got_byte[$];
  int         got_rden_cyc[$];
  int         got_vrise_cyc[$];
  int         n_done = 0;
  int         n_err = 0;
  int         n_busy = 0;
  int         last_done_cyc = 0;
  int         start_cyc = 0;

  // Compare process, sampling away from the active edge.
  initial begin
    bit         stall = 1'b0;
    bit         valid_prev = 1'b0;
    logic [7:0] stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall      = 1'b0;
        valid_prev = 1'b0;
      end else begin
        if (stall) begin
          check("valid held under backpressure", 64'(tx_valid), 64'd1);
          check("data held under backpressure", 64'(tx_data), 64'(stall_data));
        end
        if (rden) begin
          if (got_addr.size() < exp_addr.size())
            check("rdaddress", 64'(rdaddress), 64'(exp_addr[got_addr.size()]));
          else
            check("unexpected rden", 64'(rden), 64'd0);
          got_addr.push_back(int'(rdaddress));
          got_rden_cyc.push_back(cyc);
        end
        if (tx_valid && !valid_prev) got_vrise_cyc.push_back(cyc);
        if (tx_valid && tx_ready) begin
          if (got_byte.size() < exp_byte.size())
            check("tx_data", 64'(tx_data), 64'(exp_byte[got_byte.size()]));
          else
            check("unexpected byte", 64'(tx_valid), 64'd0);
          got_byte.push_back(tx_data);
        end
        if (done) begin
          n_done++;
          last_done_cyc = cyc;
        end
        if (err) begin
          n_err++;
          check("err coincident with done", 64'(done), 64'd1);
        end
        if (busy) n_busy++;
        stall      = tx_valid && !tx_ready;
        stall_data = tx_data;
        valid_prev = tx_valid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drop model entries left over from an aborted or reset readout.
  task automatic align_model();
    while (exp_addr.size() > got_addr.size()) void'(exp_addr.pop_back());
    while (exp_byte.size() > got_byte.size()) void'(exp_byte.pop_back());
  endtask

  task automatic launch(input logic [W-1:0] w, input logic [W-1:0] t, input int len,
                        input logic [3:0] m);
    logic [W-1:0] b;
    int base;
    align_model();
    b = w - t;
    base = int'(b);
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int i = 0; i < len; i++) begin
          exp_addr.push_back((base + i) % Depth);
          exp_byte.push_back(ram_val(ch, (base + i) % Depth));
        end
      end
    end
    wtp       = w;
    tp        = t;
    readlen   = (W + 1)'(len);
    chanmask  = m;
    start     = 1'b1;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int  d0;
    bit  ok;
    d0 = n_done;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (n_done != d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, r0, v0, d0, e0, bz0, uniq;
    bit seen [Depth];

    tick(2);
    check("reset outputs", 64'({rden, rdaddress, tx_data, tx_valid, busy, done, err}), 64'd0);
    rstn        = 1'b1;
    data_ready  = 1'b1;
    ready_fixed = 1'b1;
    tick(3);

    // Basic wrap around the end of the buffer.
    a0 = got_addr.size(); b0 = got_byte.size();
    r0 = got_rden_cyc.size(); v0 = got_vrise_cyc.size(); e0 = n_err;
    launch(10'd5, 10'd20, 32, 4'b0001);
    check("model first addr", 64'(exp_addr[a0]), 64'd1009);
    check("model first byte", 64'(exp_byte[b0]), 64'hF1);
    wait_done(200);
    check("wrap done cycle", 64'(last_done_cyc - start_cyc), 64'd98);
    check("wrap first rden cycle", 64'(got_rden_cyc[r0] - start_cyc), 64'd2);
    check("wrap first valid cycle", 64'(got_vrise_cyc[v0] - start_cyc), 64'd4);
    check("wrap first addr", 64'(got_addr[a0]), 64'd1009);
    check("wrap addr after wrap", 64'(got_addr[a0 + 15]), 64'd0);
    check("wrap last addr", 64'(got_addr[a0 + 31]), 64'd16);
    check("wrap first byte", 64'(got_byte[b0]), 64'hF1);
    check("wrap last byte", 64'(got_byte[b0 + 31]), 64'h10);
    check("wrap byte count", 64'(got_byte.size() - b0), 64'd32);
    check("wrap no err", 64'(n_err - e0), 64'd0);
    check("busy low after done", 64'(busy), 64'd0);

    // Multi-channel order.
    a0 = got_addr.size(); b0 = got_byte.size(); d0 = n_done;
    launch(10'd0, 10'd0, 4, 4'b1010);
    wait_done(100);
    check("multi done cycle", 64'(last_done_cyc - start_cyc), 64'd26);
    tick(5);
    check("multi rden count", 64'(got_addr.size() - a0), 64'd8);
    check("multi single done", 64'(n_done - d0), 64'd1);
    check("multi first byte q2", 64'(got_byte[b0]), 64'h40);
    check("multi fourth byte q2", 64'(got_byte[b0 + 3]), 64'h43);
    check("multi fifth byte q4", 64'(got_byte[b0 + 4]), 64'hC0);

    // Random backpressure on all channels.
    b0 = got_byte.size(); e0 = n_err;
    rand_mode = 1'b1;
    launch(10'd100, 10'd3, 5, 4'b1111);
    wait_done(1000);
    rand_mode = 1'b0;
    tick(2);
    check("backpressure byte count", 64'(got_byte.size() - b0), 64'd20);
    check("backpressure no err", 64'(n_err - e0), 64'd0);

    // Degenerate requests.
    a0 = got_addr.size(); v0 = got_vrise_cyc.size();
    launch(10'd7, 10'd2, 0, 4'b0011);
    wait_done(20);
    check("readlen0 done cycle", 64'(last_done_cyc - start_cyc), 64'd2);
    launch(10'd7, 10'd2, 5, 4'b0000);
    wait_done(20);
    check("mask0 done cycle", 64'(last_done_cyc - start_cyc), 64'd2);
    check("degenerate no rden", 64'(got_addr.size() - a0), 64'd0);
    check("degenerate no valid", 64'(got_vrise_cyc.size() - v0), 64'd0);

    // Start without data_ready.
    d0 = n_done; bz0 = n_busy;
    data_ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check("no data_ready busy", 64'(n_busy - bz0), 64'd0);
    check("no data_ready done", 64'(n_done - d0), 64'd0);
    data_ready = 1'b1;
    tick(1);

    // Full-depth readout reads every address exactly once.
    a0 = got_addr.size();
    launch(10'd0, 10'd0, 1024, 4'b0001);
    wait_done(4000);
    check("full done cycle", 64'(last_done_cyc - start_cyc), 64'd3074);
    check("full rden count", 64'(got_addr.size() - a0), 64'd1024);
    uniq = 0;
    for (int i = a0; i < got_addr.size(); i++) begin
      if (!seen[got_addr[i] % Depth]) uniq++;
      seen[got_addr[i] % Depth] = 1'b1;
    end
    check("full distinct addresses", 64'(uniq), 64'd1024);

    // Abort while a byte is stalled in SEND.
    a0 = got_addr.size(); b0 = got_byte.size(); d0 = n_done; e0 = n_err;
    ready_fixed = 1'b0;
    tick(1);
    launch(10'd50, 10'd0, 8, 4'b0001);
    for (int i = 0; i < 20 && !tx_valid; i++) tick(1);
    check("abort reached send", 64'(tx_valid), 64'd1);
    data_ready = 1'b0;
    tick(4);
    check("abort valid held", 64'(tx_valid), 64'd1);
    check("abort no early done", 64'(n_done - d0), 64'd0);
    ready_fixed = 1'b1;
    wait_done(20);
    check("abort err pulse", 64'(n_err - e0), 64'd1);
    tick(5);
    check("abort rden count", 64'(got_addr.size() - a0), 64'd1);
    check("abort byte count", 64'(got_byte.size() - b0), 64'd1);
    data_ready = 1'b1;
    tick(2);

    // Reset mid-stream, with an ignored start and input changes beforehand.
    b0 = got_byte.size();
    launch(10'd200, 10'd10, 10, 4'b0001);
    for (int i = 0; i < 100 && (got_byte.size() - b0) < 3; i++) tick(1);
    wtp = 10'd500;
    chanmask = 4'b1111;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 100 && (got_byte.size() - b0) < 5; i++) tick(1);
    check("busy before reset", 64'(busy), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("outputs zero in reset", 64'({rden, rdaddress, tx_data, tx_valid, busy, done, err}),
          64'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    a0 = got_addr.size(); b0 = got_byte.size();
    launch(10'd300, 10'd0, 3, 4'b0001);
    wait_done(100);
    check("restart first addr", 64'(got_addr[a0]), 64'd300);
    check("restart byte count", 64'(got_byte.size() - b0), 64'd3);
    check("restart done cycle", 64'(last_done_cyc - start_cyc), 64'd11);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
